// File: rtl/conv3d_seq_ctrl.sv
// Sequencer for a 3-channel 3x3 convolution engine: loads 27 weights, clears and
// kernel-loads the engine, streams pixel triples in and forwards the summed results out.
module conv3d_seq_ctrl #(
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3,
    parameter int Datawidth  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [Datawidth-1:0] w_data,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [Datawidth-1:0] pix_0,
    input  logic [Datawidth-1:0] pix_1,
    input  logic [Datawidth-1:0] pix_2,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 conv_rst,
    output logic                 load_kernel,
    input  logic [2:0]           counter_kernel,
    input  logic                 load_kernel_done,
    output logic [Datawidth-1:0] k0,
    output logic [Datawidth-1:0] k1,
    output logic [Datawidth-1:0] k2,
    output logic [Datawidth-1:0] k3,
    output logic [Datawidth-1:0] k4,
    output logic [Datawidth-1:0] k5,
    output logic [Datawidth-1:0] k6,
    output logic [Datawidth-1:0] k7,
    output logic [Datawidth-1:0] k8,
    output logic                 valid_in,
    output logic [Datawidth-1:0] In_0,
    output logic [Datawidth-1:0] In_1,
    output logic [Datawidth-1:0] In_2,
    input  logic [Datawidth-1:0] Out,
    input  logic                 valid_out,
    output logic [Datawidth-1:0] res_data,
    output logic                 res_valid,
    output logic                 res_last,
    output logic                 busy,
    output logic                 done
);

    localparam int N_W    = 27;
    localparam int N_PIX  = IMG_Width * IMG_Height;
    localparam int N_OUT  = (IMG_Width - 2) * (IMG_Height - 2);
    localparam int PIX_CW = $clog2(N_PIX + 1);
    localparam int RES_CW = $clog2(N_OUT + 1);
    localparam logic [4:0] W_LAST = 5'd26;

    typedef enum logic [2:0] {IDLE, LOAD_W, CLR, KLOAD, STREAM, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [4:0]           w_cnt;
    logic [PIX_CW-1:0]    pix_cnt;
    logic [RES_CW-1:0]    res_cnt;
    logic [Datawidth-1:0] bank [N_W];
    logic [4:0]           k_base;
    logic                 w_acc, pix_acc, res_acc, res_final;

    assign w_acc     = w_valid && w_ready;
    assign pix_acc   = pix_valid && pix_ready;
    // Results only count while the engine is actually being fed; strays elsewhere are dropped.
    assign res_acc   = valid_out && (state == STREAM || state == DRAIN);
    assign res_final = res_acc && (res_cnt == RES_CW'(N_OUT - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nxt   = state;
        w_ready     = 1'b0;
        pix_ready   = 1'b0;
        load_kernel = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        conv_rst    = ~rst || (state == CLR);
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD_W;
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_acc && w_cnt == W_LAST) state_nxt = CLR;
            end
            CLR:     state_nxt = KLOAD;
            KLOAD: begin
                load_kernel = 1'b1;
                if (load_kernel_done) state_nxt = STREAM;
            end
            STREAM: begin
                pix_ready = (pix_cnt < PIX_CW'(N_PIX));
                if (res_final)                                        state_nxt = DONE;
                else if (pix_acc && pix_cnt == PIX_CW'(N_PIX - 1))    state_nxt = DRAIN;
            end
            DRAIN:   if (res_final) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        k_base = 5'd18;
        if (counter_kernel == 3'd0)      k_base = 5'd0;
        else if (counter_kernel == 3'd1) k_base = 5'd9;
    end

    assign k0 = bank[k_base];
    assign k1 = bank[k_base + 5'd1];
    assign k2 = bank[k_base + 5'd2];
    assign k3 = bank[k_base + 5'd3];
    assign k4 = bank[k_base + 5'd4];
    assign k5 = bank[k_base + 5'd5];
    assign k6 = bank[k_base + 5'd6];
    assign k7 = bank[k_base + 5'd7];
    assign k8 = bank[k_base + 5'd8];

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            w_cnt     <= '0;
            pix_cnt   <= '0;
            res_cnt   <= '0;
            valid_in  <= 1'b0;
            In_0      <= '0;
            In_1      <= '0;
            In_2      <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
            // NOTE: the weight bank is flops, not RAM, so it can be cleared and the kernel bus reads 0 in reset.
            for (int i = 0; i < N_W; i++) bank[i] <= '0;
        end else begin
            state     <= state_nxt;
            valid_in  <= pix_acc;
            res_valid <= res_acc;
            res_last  <= res_final;
            if (pix_acc) begin
                In_0 <= pix_0;
                In_1 <= pix_1;
                In_2 <= pix_2;
            end
            if (res_acc) res_data <= Out;
            if (state == IDLE && start) begin
                w_cnt   <= '0;
                pix_cnt <= '0;
                res_cnt <= '0;
            end else begin
                // Each increment is gated by a handshake that can no longer occur at the maximum.
                if (w_acc) begin
                    bank[w_cnt] <= w_data;
                    w_cnt       <= w_cnt + 5'd1;
                end
                if (pix_acc) pix_cnt <= pix_cnt + PIX_CW'(1);
                if (res_acc) res_cnt <= res_cnt + RES_CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv3d_seq_ctrl.sv
// Self-checking bench for conv3d_seq_ctrl: the bench plays the convolution engine and
// checks each job phase against expectations derived from the weight/pixel/result rules.
module tb_conv3d_seq_ctrl;

    localparam int W     = 3;
    localparam int H     = 3;
    localparam int DW    = 32;
    localparam int N_PIX = W * H;

    logic          clk, rst, start;
    logic [DW-1:0] w_data;
    logic          w_valid, w_ready;
    logic [DW-1:0] pix_0, pix_1, pix_2;
    logic          pix_valid, pix_ready;
    logic          conv_rst, load_kernel;
    logic [2:0]    counter_kernel;
    logic          load_kernel_done;
    logic [DW-1:0] k0, k1, k2, k3, k4, k5, k6, k7, k8;
    logic          valid_in;
    logic [DW-1:0] In_0, In_1, In_2;
    logic [DW-1:0] Out;
    logic          valid_out;
    logic [DW-1:0] res_data;
    logic          res_valid, res_last, busy, done;

    conv3d_seq_ctrl #(.IMG_Width(W), .IMG_Height(H), .Datawidth(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .pix_0(pix_0), .pix_1(pix_1), .pix_2(pix_2),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .conv_rst(conv_rst), .load_kernel(load_kernel),
        .counter_kernel(counter_kernel), .load_kernel_done(load_kernel_done),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3), .k4(k4), .k5(k5), .k6(k6), .k7(k7), .k8(k8),
        .valid_in(valid_in), .In_0(In_0), .In_1(In_1), .In_2(In_2),
        .Out(Out), .valid_out(valid_out),
        .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] kv [9];
    assign kv[0] = k0; assign kv[1] = k1; assign kv[2] = k2;
    assign kv[3] = k3; assign kv[4] = k4; assign kv[5] = k5;
    assign kv[6] = k6; assign kv[7] = k7; assign kv[8] = k8;

    typedef struct {
        logic [2:0]    ck;
        logic [DW-1:0] e_k0;
        logic [DW-1:0] e_k4;
        logic [DW-1:0] e_k8;
    } kvec_t;
    kvec_t ktab [5];

    logic [DW-1:0] wts [27];
    int n_checks = 0;
    int n_fail   = 0;

    // Event counters outside reset, used to prove "exactly once" / "never" properties per job.
    int mon_crst = 0;
    int mon_done = 0;
    int mon_resv = 0;
    int mon_last = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (conv_rst)  mon_crst++;
            if (done)      mon_done++;
            if (res_valid) mon_resv++;
            if (res_last)  mon_last++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input bit seq_w, input bit w_toggle, input bit pix_stall,
                           input bit res_in_stream, input bit poke_start, input int abort_at);
        int c_crst, c_done, c_resv, c_last;
        int nacc, np, guard, stall, rk;
        bit ph, acc, got_res;
        logic [DW-1:0] rv, p0, p1, p2;
        c_crst = mon_crst; c_done = mon_done; c_resv = mon_resv; c_last = mon_last;

        start = 1'b1; tick(); start = 1'b0;
        check("busy_after_start", busy, 1);
        check("w_ready_in_load", w_ready, 1);

        for (int i = 0; i < 27; i++) wts[i] = seq_w ? DW'(i + 1) : DW'($urandom);
        nacc = 0; guard = 0; ph = 1'b0;
        while (nacc < 27 && guard < 200) begin
            w_valid = w_toggle ? ph : 1'b1;
            ph      = ~ph;
            w_data  = w_valid ? wts[nacc] : DW'($urandom);
            acc     = w_valid && w_ready;
            tick();
            if (acc) nacc++;
            guard++;
        end
        check("weights_accepted", nacc, 27);
        w_valid = 1'b1; w_data = 32'hdead_beef;
        check("conv_rst_in_clr", conv_rst, 1);
        check("w_ready_after_load", w_ready, 0);
        tick();
        check("conv_rst_one_cycle", conv_rst, 0);
        check("load_kernel_in_kload", load_kernel, 1);
        check("w_ready_in_kload", w_ready, 0);
        w_valid = 1'b0;

        if (seq_w) begin
            foreach (ktab[j]) begin
                counter_kernel = ktab[j].ck; #1;
                check($sformatf("k0_tab%0d", j), k0, ktab[j].e_k0);
                check($sformatf("k4_tab%0d", j), k4, ktab[j].e_k4);
                check($sformatf("k8_tab%0d", j), k8, ktab[j].e_k8);
            end
        end else begin
            for (int ck = 0; ck < 4; ck++) begin
                counter_kernel = 3'(ck); #1;
                for (int i = 0; i < 9; i++)
                    check($sformatf("k%0d_sel%0d", i, ck), kv[i], wts[(ck > 2 ? 2 : ck) * 9 + i]);
            end
        end
        rk = $urandom_range(0, 3);
        repeat (rk) tick();
        check("load_kernel_hold", load_kernel, 1);
        load_kernel_done = 1'b1; tick(); load_kernel_done = 1'b0;
        check("load_kernel_drop", load_kernel, 0);
        check("pix_ready_stream", pix_ready, 1);

        np = 0; guard = 0; stall = 0; got_res = 1'b0;
        while (np < N_PIX && guard < 200 && !got_res) begin
            guard++;
            if (abort_at == np) begin
                pix_valid = 1'b0; rst = 1'b0; #1;
                check("abort_busy", busy, 0);
                check("abort_conv_rst", conv_rst, 1);
                check("abort_pix_ready", pix_ready, 0);
                check("abort_load_kernel", load_kernel, 0);
                check("abort_valid_in", valid_in, 0);
                check("abort_k0", k0, 0);
                check("abort_done", done, 0);
                tick(); rst = 1'b1;
                Out = DW'($urandom); valid_out = 1'b1; tick(); valid_out = 0;
                repeat (3) tick();
                check("abort_idle", busy, 0);
                check("abort_no_res", res_valid, 0);
                check("abort_done_count", mon_done - c_done, 0);
                check("abort_last_count", mon_last - c_last, 0);
                check("abort_res_count", mon_resv - c_resv, 0);
                return;
            end
            if (res_in_stream && np == 4) begin
                pix_valid = 1'b0;
                rv = DW'($urandom); Out = rv; valid_out = 1'b1;
                tick(); valid_out = 1'b0;
                got_res = 1'b1;
            end else begin
                pix_valid = !(pix_stall && np == 4 && stall < 5);
                if (!pix_valid) stall++;
                p0 = DW'($urandom); p1 = DW'($urandom); p2 = DW'($urandom);
                pix_0 = p0; pix_1 = p1; pix_2 = p2;
                acc = pix_valid && pix_ready;
                tick();
                if (acc) begin
                    check("valid_in_on_accept", valid_in, 1);
                    check("in_0", In_0, p0);
                    check("in_1", In_1, p1);
                    check("in_2", In_2, p2);
                    np++;
                end else begin
                    check("valid_in_stall", valid_in, 0);
                end
            end
        end

        if (!got_res) begin
            check("pix_count", np, N_PIX);
            check("pix_ready_after_last", pix_ready, 0);
            pix_valid = 1'b1; tick();
            check("valid_in_no_extra", valid_in, 0);
            pix_valid = 1'b0;
            if (poke_start) begin
                start = 1'b1; tick(); start = 1'b0;
                check("busy_in_drain", busy, 1);
            end
            rk = $urandom_range(0, 3);
            repeat (rk) tick();
            rv = DW'($urandom); Out = rv; valid_out = 1'b1;
            tick(); valid_out = 1'b0;
        end

        check("res_valid", res_valid, 1);
        check("res_data", res_data, rv);
        check("res_last", res_last, 1);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("pix_ready_in_done", pix_ready, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("busy_cleared", busy, 0);
        check("res_valid_one_cycle", res_valid, 0);
        repeat (2) tick();
        check("idle_stays", busy, 0);
        check("conv_rst_pulses", mon_crst - c_crst, 1);
        check("done_pulses", mon_done - c_done, 1);
        check("res_count", mon_resv - c_resv, 1);
        check("last_count", mon_last - c_last, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int c_resv;
        ktab[0] = '{ck: 3'd0, e_k0: 32'd1,  e_k4: 32'd5,  e_k8: 32'd9};
        ktab[1] = '{ck: 3'd1, e_k0: 32'd10, e_k4: 32'd14, e_k8: 32'd18};
        ktab[2] = '{ck: 3'd2, e_k0: 32'd19, e_k4: 32'd23, e_k8: 32'd27};
        ktab[3] = '{ck: 3'd3, e_k0: 32'd19, e_k4: 32'd23, e_k8: 32'd27};
        ktab[4] = '{ck: 3'd7, e_k0: 32'd19, e_k4: 32'd23, e_k8: 32'd27};

        rst = 1'b0; start = 1'b0; w_data = '0; w_valid = 1'b0;
        pix_0 = '0; pix_1 = '0; pix_2 = '0; pix_valid = 1'b0;
        counter_kernel = 3'd0; load_kernel_done = 1'b0; Out = '0; valid_out = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_conv_rst", conv_rst, 1);
        check("rst_w_ready", w_ready, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_load_kernel", load_kernel, 0);
        check("rst_valid_in", valid_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last", res_last, 0);
        check("rst_done", done, 0);
        check("rst_k0", k0, 0);
        check("rst_res_data", res_data, 0);
        check("rst_in_0", In_0, 0);
        rst = 1'b1; tick();
        check("idle_conv_rst", conv_rst, 0);
        check("idle_busy", busy, 0);

        c_resv = mon_resv;
        Out = 32'h1234_5678; valid_out = 1'b1;
        repeat (2) tick();
        valid_out = 1'b0;
        check("idle_res_valid", res_valid, 0);
        check("idle_res_discard", mon_resv - c_resv, 0);

        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // full job, weights 1..27, kernel table
        run_job(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);  // weight backpressure
        run_job(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);  // pixel stall
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);   // reset mid-stream
        run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // recovery job
        run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);  // start during drain
        run_job(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);  // final result during stream
        for (int j = 0; j < 8; j++)
            run_job(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
